// File: rtl/fft_pkg.sv
// Shared types and helpers for the ping-pong FFT engine and its frame sequencer.
package fft_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int MAX_LOG2N          = 16;

    typedef struct packed {
        logic signed [DEFAULT_DATA_WIDTH-1:0] re;
        logic signed [DEFAULT_DATA_WIDTH-1:0] im;
    } complex_t;

    typedef struct packed {
        logic [4:0]  stage;
        logic [15:0] half_span;
        logic [15:0] twiddle_step;
    } stage_info_t;

    // Reverses the low 'width' bits of value; bits above width come back zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                     input int width);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < width) r[4'(i)] = value[4'(width - 1 - i)];
        end
        return r;
    endfunction

    // Each radix-2 stage swaps banks, so the result lands in bank (LOG2N % 2).
    function automatic logic result_bank(input int log2n);
        return log2n[0];
    endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry valid/ready output buffer with fall-through when empty, so read data
// reaches the output in the same cycle it returns from the bank RAM.
module fft_out_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty     = (count == 2'd0);
    assign bypass    = in_valid && empty && out_ready;
    assign push      = in_valid && !bypass;
    assign pop       = out_ready && !empty;
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : entry[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: payload storage is deliberately not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) entry[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: loads a frame bit-reversed into bank 0, kicks the FFT engine,
// then streams the result bank out in natural order, with a run watchdog.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 4 * N * $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    output logic                      out_last,
    output logic [$clog2(N)-1:0]      out_index,
    output logic                      fft_start,
    input  logic                      fft_finish,
    output logic                      mem_own,
    output logic                      mem_bank,
    output logic [$clog2(N)-1:0]      mem_addr,
    output logic                      mem_we,
    output logic [2*DATA_WIDTH-1:0]   mem_wdata,
    input  logic [2*DATA_WIDTH-1:0]   mem_rdata,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      error
);

    localparam int   LOG2N       = $clog2(N);
    localparam int   SW          = 2 * DATA_WIDTH;
    localparam int   WD_W        = $clog2(TIMEOUT + 1);
    localparam int   SKID_W      = SW + LOG2N + 1;
    localparam logic RESULT_BANK = result_bank(LOG2N);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic             live;
    logic [LOG2N-1:0] load_cnt;
    logic [LOG2N:0]   rd_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             rd_pend;
    logic [LOG2N-1:0] rd_pend_idx;
    logic             rd_issue;
    logic             in_fire;
    logic             out_fire;
    logic [1:0]       skid_count;
    logic [SKID_W-1:0] skid_in;
    logic [SKID_W-1:0] skid_out;

    // 'live' keeps in_ready and the port mux quiet for the whole reset cycle.
    assign in_ready   = live && (state == S_LOAD);
    assign in_fire    = in_ready && in_valid;
    assign out_fire   = out_valid && out_ready;
    assign fft_start  = (state == S_START);
    assign busy       = (state == S_START) || (state == S_RUN);
    assign frame_done = out_fire && out_last;

    // Skid occupancy plus the read returning this cycle never exceeds two entries.
    assign rd_issue = (state == S_DRAIN) && !rd_cnt[LOG2N]
                      && ((skid_count + {1'b0, rd_pend}) < 2'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            live        <= 1'b0;
            load_cnt    <= '0;
            rd_cnt      <= '0;
            wd_cnt      <= '0;
            rd_pend     <= 1'b0;
            rd_pend_idx <= '0;
            error       <= 1'b0;
        end else begin
            live    <= 1'b1;
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_pend_idx <= rd_cnt[LOG2N-1:0];
                rd_cnt      <= rd_cnt + 1'b1;
            end
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == LOG2N'(N - 1)) state <= S_START;
                    end
                end
                S_START: begin
                    wd_cnt <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (fft_finish) begin
                        wd_cnt <= '0;
                        rd_cnt <= '0;
                        state  <= S_DRAIN;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        error    <= 1'b1;
                        wd_cnt   <= '0;
                        load_cnt <= '0;
                        rd_cnt   <= '0;
                        state    <= S_LOAD;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (frame_done) begin
                        load_cnt <= '0;
                        rd_cnt   <= '0;
                        state    <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // NOTE: every output of this always_comb gets a default first so no latch is inferred.
    always_comb begin
        mem_own   = 1'b0;
        mem_bank  = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_LOAD: begin
                if (live) begin
                    mem_own   = 1'b1;
                    mem_addr  = LOG2N'(bitrev(MAX_LOG2N'(load_cnt), LOG2N));
                    mem_we    = in_valid;
                    mem_wdata = in_data;
                end
            end
            S_DRAIN: begin
                mem_own  = 1'b1;
                mem_bank = RESULT_BANK;
                mem_addr = rd_cnt[LOG2N-1:0];
            end
            default: ;
        endcase
    end

    assign skid_in = rd_pend ? {(rd_pend_idx == LOG2N'(N - 1)), rd_pend_idx, mem_rdata}
                             : '0;

    fft_out_skid #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_pend),
        .in_data   (skid_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out),
        .count     (skid_count)
    );

    assign {out_last, out_index, out_data} = skid_out;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a two-bank registered RAM model acting as the engine side.
module tb_fft_frame_sequencer;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int LOG2N = 3;
    localparam int SW    = 2 * DW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SW-1:0]    out_data;
    logic             out_last;
    logic [LOG2N-1:0] out_index;
    logic             fft_start;
    logic             fft_finish = 1'b0;
    logic             mem_own;
    logic             mem_bank;
    logic [LOG2N-1:0] mem_addr;
    logic             mem_we;
    logic [SW-1:0]    mem_wdata;
    logic [SW-1:0]    mem_rdata = '0;
    logic             busy;
    logic             frame_done;
    logic             error;

    logic [SW-1:0] bank0 [N];
    logic [SW-1:0] bank1 [N];

    int n_vec = 0;
    int n_err = 0;
    int addr_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    fft_frame_sequencer #(.N(N), .DATA_WIDTH(DW), .TIMEOUT(96)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_index(out_index),
        .fft_start(fft_start), .fft_finish(fft_finish),
        .mem_own(mem_own), .mem_bank(mem_bank), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .frame_done(frame_done), .error(error)
    );

    // Bank 1 is owned by the bench (engine side); the sequencer only ever writes bank 0.
    always @(posedge clk) begin
        if (mem_own) begin
            if (mem_bank) begin
                mem_rdata <= bank1[mem_addr];
            end else begin
                if (mem_we) bank0[mem_addr] <= mem_wdata;
                mem_rdata <= bank0[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [SW-1:0] base);
        for (int i = 0; i < N; i++) bank1[i] = base + SW'(i);
    endtask

    // Ends in the first RUN cycle.
    task automatic load_frame(input logic [SW-1:0] base);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = base + SW'(k);
            #1;
            check("load_ready", in_ready, 1);
            check("load_we", mem_we, 1);
            check("load_addr", mem_addr, addr_tab[k]);
            check("load_nostart", fft_start, 0);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        check("start_pulse", fft_start, 1);
        check("start_busy", busy, 1);
        check("start_own", mem_own, 0);
        check("start_ready", in_ready, 0);
        step();
        check("run_nostart", fft_start, 0);
        check("run_busy", busy, 1);
        for (int k = 0; k < N; k++) check("bank0_order", bank0[addr_tab[k]], base + SW'(k));
    endtask

    // Called in a RUN cycle f; pulses finish and drains with out_ready held high.
    task automatic drain_full(input logic [SW-1:0] base, input logic exp_err);
        fft_finish = 1'b1;
        out_ready  = 1'b1;
        step();
        fft_finish = 1'b0;
        #1;
        check("drain_first_valid", out_valid, 0);
        check("drain_own", mem_own, 1);
        check("drain_bank", mem_bank, 1);
        check("drain_we", mem_we, 0);
        check("drain_addr0", mem_addr, 0);
        check("drain_busy", busy, 0);
        for (int i = 0; i < N; i++) begin
            step();
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, base + SW'(i));
            check("drain_index", out_index, i);
            check("drain_last", out_last, i == N - 1);
            check("drain_done", frame_done, i == N - 1);
        end
        step();
        check("after_ready", in_ready, 1);
        check("after_valid", out_valid, 0);
        check("after_error", error, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int   n_acc;
        int   acc_before;
        logic done;
        logic prev_stall;
        logic [SW-1:0] prev_data;

        // Reset state
        repeat (3) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_own", mem_own, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_start", fft_start, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", in_ready, 1);

        // Spurious finish in LOAD
        fft_finish = 1'b1;
        step();
        fft_finish = 1'b0;
        #1;
        check("spur_ready", in_ready, 1);
        check("spur_busy", busy, 0);
        check("spur_start", fft_start, 0);
        check("spur_own", mem_own, 1);

        // Full frame, no backpressure
        preload(32'h100);
        load_frame(32'h0);
        step();
        drain_full(32'h100, 1'b0);

        // Output backpressure
        preload(32'h200);
        out_ready = 1'b0;
        load_frame(32'h10);
        fft_finish = 1'b1;
        step();
        fft_finish = 1'b0;
        n_acc = 0;
        done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            out_ready = pat[c % 4];
            #1;
            acc_before = n_acc;
            if (prev_stall) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_data", out_data, prev_data);
            end
            if (mem_addr != 0) check("bp_outstanding", (int'(mem_addr) - acc_before) <= 2, 1);
            if (out_valid && out_ready) begin
                check("bp_data", out_data, 32'h200 + n_acc);
                check("bp_index", out_index, n_acc);
                check("bp_last", out_last, n_acc == N - 1);
                if (out_last) begin
                    check("bp_done", frame_done, 1);
                    done = 1'b1;
                end
                n_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
        end
        check("bp_count", n_acc, N);
        check("bp_back_to_load", in_ready, 1);

        // Watchdog: no finish for 96 RUN cycles
        load_frame(32'h20);
        repeat (95) step();
        check("wd_busy_last", busy, 1);
        check("wd_no_err_yet", error, 0);
        step();
        check("wd_error", error, 1);
        check("wd_load", in_ready, 1);
        check("wd_busy", busy, 0);

        // Good frame after abort keeps error set
        preload(32'h400);
        load_frame(32'h30);
        drain_full(32'h400, 1'b1);

        // Reset in the middle of DRAIN
        preload(32'h500);
        load_frame(32'h40);
        fft_finish = 1'b1;
        out_ready  = 1'b1;
        step();
        fft_finish = 1'b0;
        repeat (4) step();
        check("mid_index3", out_index, 3);
        check("mid_data3", out_data, 32'h503);
        rst_n = 1'b0;
        step();
        check("mrst_in_ready", in_ready, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_out_index", out_index, 0);
        check("mrst_busy", busy, 0);
        check("mrst_own", mem_own, 0);
        check("mrst_error", error, 0);
        check("mrst_done", frame_done, 0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();
        check("mrst_ready_back", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 32'haa;
        #1;
        check("mrst_load_addr0", mem_addr, 0);
        check("mrst_load_we", mem_we, 1);
        step();
        in_valid = 1'b0;
        #1;
        check("mrst_load_addr1", mem_addr, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
